fetch_regs: RTL and testbench
=============================

# fetch_regs

Instruction-side register stage of the multicycle MIPS datapath, sitting directly downstream of the control FSM and consuming its PCWrite/PCWriteCond/IorD/IRWrite/PCSource outputs. Holds the PC, instruction register (IR) and memory data register (MDR). Selects the shared-memory address, evaluates the PC update including conditional branches and jumps, and returns the decoded opcode to the control FSM. Also keeps a retired-fetch counter for bring-up and performance checks.

## Interface
- `WIDTH`, 32: datapath width; all address and data buses.
- `RESET_PC`, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pc_write`  in  1  unconditional PC write (control PCWrite).
- `pc_write_cond`  in  1  PC write gated by `alu_zero` (control PCWriteCond).
- `i_or_d`  in  1  memory address select: 0 = PC, 1 = `alu_out`.
- `ir_write`  in  1  capture `mem_rdata` into IR.
- `pc_source`  in  2  next-PC select: 00 `alu_result`, 01 `alu_out`, 10 jump target, 11 hold.
- `alu_zero`  in  1  ALU zero flag, same cycle as `pc_write_cond`.
- `alu_result`  in  WIDTH  combinational ALU output.
- `alu_out`  in  WIDTH  registered ALU output (ALUOut).
- `mem_rdata`  in  WIDTH  combinational memory read data.
- `mem_addr`  out  WIDTH  memory address.
- `pc`  out  WIDTH  current PC register.
- `ir`  out  WIDTH  instruction register.
- `opcode`  out  6  `ir[31:26]`, to control FSM.
- `rs`, `rt`, `rd`  out  5 each  `ir[25:21]`, `ir[20:16]`, `ir[15:11]`.
- `funct`  out  6  `ir[5:0]`.
- `imm_sext`  out  WIDTH  `ir[15:0]` sign-extended.
- `mdr`  out  WIDTH  memory data register.
- `fetch_count`  out  32  number of IR captures since reset.

## Operation
- `mem_addr` = `i_or_d` ? `alu_out` : `pc`, combinational.
- PC enable: `pc_en` = `pc_write` | (`pc_write_cond` & `alu_zero`). Both controls high counts as enabled.
- Next PC by `pc_source`:
  - 00: `alu_result` (PC+4 in fetch).
  - 01: `alu_out` (branch target).
  - 10: `{pc[31:28], ir[25:0], 2'b00}`. Uses the already-incremented PC register.
  - 11: PC unchanged even if `pc_en`.
- Bits [1:0] of every value written to PC are forced to 0.
- IR loads `mem_rdata` when `ir_write`=1, otherwise holds.
- MDR loads `mem_rdata` every cycle, unconditionally.
- `fetch_count` increments by 1 on each edge with `ir_write`=1 and wraps from 32'hFFFF_FFFF to 0.
- Field outputs and `imm_sext` are combinational from the IR register, never from `mem_rdata`.

## Timing
- Reset (`rst_n`=0, async, any time): `pc`=RESET_PC, `ir`=0, `mdr`=0, `fetch_count`=0. Outputs reflect these immediately without waiting for a clock edge.
- During reset: `mem_addr` = `i_or_d` ? `alu_out` : RESET_PC; `opcode`, `rs`, `rt`, `rd`, `funct`=0; `imm_sext`=0.
- Reset deasserted mid-instruction: any partially executed instruction is discarded and execution restarts at RESET_PC. The control FSM is responsible for returning to fetch.
- Fetch cycle (`pc_write`=`ir_write`=1, `i_or_d`=0):
  - IR captures the word at the old PC.
  - PC becomes `alu_result` at the same edge.
  - New IR and PC are visible the following cycle, when `opcode` is valid for the decode branch.
- Branch cycle: PC update occurs at the edge ending the cycle with `pc_write_cond`=1 only if `alu_zero`=1 in that cycle.
- Load: MDR holds the word addressed by `alu_out` in the cycle after the memory-read cycle, as required by write-back.
- Latency: one edge from control/data inputs to every register; zero cycles for `mem_addr` and the field outputs.

## Test plan
- Reset: pulse `rst_n` low between edges with RESET_PC=32'h40 -> `pc`=32'h40, `ir`=0, `fetch_count`=0 immediately. Values hold until the next enabled edge.
- Fetch: `pc`=32'h40, `mem_rdata`=32'h8C22_0004, `alu_result`=32'h44, `pc_write`=`ir_write`=1 -> next cycle `pc`=32'h44, `opcode`=6'h23, `rs`=1, `rt`=2, `imm_sext`=32'h4, `fetch_count`=1.
- Branch:
  - `pc_write_cond`=1, `pc_source`=01, `alu_out`=32'h80, `alu_zero`=0 -> `pc` unchanged.
  - Repeat with `alu_zero`=1 -> `pc`=32'h80.
- Jump: `pc`=32'h1000_0008, IR=32'h0800_0010, `pc_write`=1, `pc_source`=10 -> `pc`=32'h1000_0040. Repeat with `pc_source`=11 -> `pc` unchanged.
- Load path and masking:
  - `i_or_d`=1, `alu_out`=32'h200 -> `mem_addr`=32'h200; next cycle `mdr` equals `mem_rdata` from that cycle and IR is unchanged.
  - `alu_result`=32'h47 with `pc_write`=1 -> `pc`=32'h44.
- Counter wrap and sign extension:
  - Force `fetch_count` to 32'hFFFF_FFFF, then apply one `ir_write` -> `fetch_count`=0.
  - IR=32'h1000_FFFC -> `imm_sext`=32'hFFFF_FFFC.

Source files
------------

// File: rtl/fetch_regs.sv
// -----------------------------------------------------------------------------
// fetch_regs
//
// Instruction-side register stage of the multicycle MIPS datapath. Holds the
// PC, the instruction register (IR) and the memory data register (MDR),
// selects the shared-memory address, evaluates the PC update (sequential,
// branch, jump, hold) and decodes the IR fields for the control FSM. A
// retired-fetch counter counts IR captures for bring-up.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   pc_write        unconditional PC write (PCWrite)
//   pc_write_cond   PC write gated by alu_zero (PCWriteCond)
//   i_or_d          memory address select: 0 = pc, 1 = alu_out
//   ir_write        capture mem_rdata into IR
//   pc_source       next-PC select: 00 alu_result, 01 alu_out, 10 jump, 11 hold
//   alu_zero        ALU zero flag, same cycle as pc_write_cond
//   alu_result      combinational ALU output
//   alu_out         registered ALU output (ALUOut)
//   mem_rdata       combinational memory read data
//   mem_addr        memory address
//   pc, ir, mdr     architectural registers
//   opcode, rs, rt, rd, funct, imm_sext   fields decoded from the IR register
//   fetch_count     number of IR captures since reset (wraps)
//
// There is no handshake on this block: every register updates on the rising
// edge its enable is high, and mem_addr plus all IR fields are combinational
// from current state, valid in the same cycle.
// -----------------------------------------------------------------------------
module fetch_regs #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_write,
    input  logic             pc_write_cond,
    input  logic             i_or_d,
    input  logic             ir_write,
    input  logic [1:0]       pc_source,
    input  logic             alu_zero,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] ir,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [5:0]       funct,
    output logic [WIDTH-1:0] imm_sext,
    output logic [WIDTH-1:0] mdr,
    output logic [31:0]      fetch_count
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] mdr_q;
    logic [31:0]      fetch_count_q;

    logic             pc_en;
    logic             pc_load;
    logic [WIDTH-1:0] pc_next;

    // Both control lines high is simply an enabled write.
    assign pc_en = pc_write | (pc_write_cond & alu_zero);

    always_comb begin
        pc_next = pc_q;
        pc_load = pc_en;
        unique case (pc_source)
            2'b00:   pc_next = alu_result;
            2'b01:   pc_next = alu_out;
            // Jump target keeps the top nibble of the already-incremented PC.
            2'b10:   pc_next = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
            // 11 holds the PC even when the enable is asserted.
            default: pc_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            mdr_q         <= '0;
            fetch_count_q <= '0;
        end else begin
            // Word alignment is enforced on every value written to the PC.
            if (pc_load) begin
                pc_q <= {pc_next[WIDTH-1:2], 2'b00};
            end
            if (ir_write) begin
                ir_q          <= mem_rdata;
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            // MDR samples every cycle; write-back reads it one cycle later.
            mdr_q <= mem_rdata;
        end
    end

    assign mem_addr    = i_or_d ? alu_out : pc_q;
    assign pc          = pc_q;
    assign ir          = ir_q;
    assign mdr         = mdr_q;
    assign fetch_count = fetch_count_q;

    // Fields come from the IR register, never straight from memory data.
    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};

endmodule

// File: tb/tb_fetch_regs.sv
// -----------------------------------------------------------------------------
// tb_fetch_regs
//
// Directed bench for fetch_regs. The driver changes inputs 1 time unit after
// a rising edge and pushes the values the DUT must show at the following
// falling edge into a scoreboard queue. A separate monitor drains the queue
// on every falling edge and compares against the selected DUT output.
// -----------------------------------------------------------------------------
module tb_fetch_regs;

    localparam int              W        = 32;
    localparam logic [W-1:0]    RESET_PC = 32'h0000_0040;

    // Output selectors for scoreboard entries.
    localparam int S_PC = 0, S_IR = 1, S_MDR = 2, S_FC = 3, S_ADDR = 4,
                   S_OP = 5, S_RS = 6, S_RT = 7, S_RD = 8, S_FN = 9, S_IMM = 10;

    logic         clk;
    logic         rst_n;
    logic         pc_write;
    logic         pc_write_cond;
    logic         i_or_d;
    logic         ir_write;
    logic [1:0]   pc_source;
    logic         alu_zero;
    logic [W-1:0] alu_result;
    logic [W-1:0] alu_out;
    logic [W-1:0] mem_rdata;
    logic [W-1:0] mem_addr;
    logic [W-1:0] pc;
    logic [W-1:0] ir;
    logic [5:0]   opcode;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rd;
    logic [5:0]   funct;
    logic [W-1:0] imm_sext;
    logic [W-1:0] mdr;
    logic [31:0]  fetch_count;

    fetch_regs #(.WIDTH(W), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_source     (pc_source),
        .alu_zero      (alu_zero),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .mem_rdata     (mem_rdata),
        .mem_addr      (mem_addr),
        .pc            (pc),
        .ir            (ir),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .funct         (funct),
        .imm_sext      (imm_sext),
        .mdr           (mdr),
        .fetch_count   (fetch_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           sel_q[$];
    string        name_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    function automatic logic [W-1:0] actual(input int sel);
        case (sel)
            S_PC:    return pc;
            S_IR:    return ir;
            S_MDR:   return mdr;
            S_FC:    return fetch_count;
            S_ADDR:  return mem_addr;
            S_OP:    return {26'd0, opcode};
            S_RS:    return {27'd0, rs};
            S_RT:    return {27'd0, rt};
            S_RD:    return {27'd0, rd};
            S_FN:    return {26'd0, funct};
            default: return imm_sext;
        endcase
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [W-1:0] v);
        name_q.push_back(name);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    // Monitor: everything queued since the last rising edge is due now.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            automatic logic [W-1:0] e = exp_q.pop_front();
            automatic int           s = sel_q.pop_front();
            automatic string        n = name_q.pop_front();
            automatic logic [W-1:0] a = actual(s);
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_source     = 2'b11;
        alu_zero      = 1'b0;
    endtask

    task automatic drive(input logic pw, input logic pwc, input logic z,
                         input logic iw, input logic [1:0] src,
                         input logic [W-1:0] res, input logic [W-1:0] aout,
                         input logic [W-1:0] rdata);
        pc_write      = pw;
        pc_write_cond = pwc;
        alu_zero      = z;
        ir_write      = iw;
        pc_source     = src;
        alu_result    = res;
        alu_out       = aout;
        mem_rdata     = rdata;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        alu_result = '0;
        alu_out    = '0;
        mem_rdata  = '0;
        idle();

        // Reset state.
        tick(); tick();
        expect_val("rst_pc", S_PC, 32'h40);
        expect_val("rst_ir", S_IR, 32'h0);
        expect_val("rst_mdr", S_MDR, 32'h0);
        expect_val("rst_fc", S_FC, 32'h0);
        expect_val("rst_op", S_OP, 32'h0);
        expect_val("rst_imm", S_IMM, 32'h0);
        expect_val("rst_addr_pc", S_ADDR, 32'h40);
        tick();
        i_or_d  = 1'b1;
        alu_out = 32'h123;
        expect_val("rst_addr_aluout", S_ADDR, 32'h123);
        tick();
        rst_n  = 1'b1;
        i_or_d = 1'b0;

        // Fetch.
        drive(1, 0, 0, 1, 2'b00, 32'h44, 32'h0, 32'h8C22_0004);
        expect_val("fetch_addr", S_ADDR, 32'h40);
        tick();
        idle();
        mem_rdata = '0;
        expect_val("fetch_pc", S_PC, 32'h44);
        expect_val("fetch_ir", S_IR, 32'h8C22_0004);
        expect_val("fetch_op", S_OP, 32'h23);
        expect_val("fetch_rs", S_RS, 32'h1);
        expect_val("fetch_rt", S_RT, 32'h2);
        expect_val("fetch_rd", S_RD, 32'h0);
        expect_val("fetch_fn", S_FN, 32'h4);
        expect_val("fetch_imm", S_IMM, 32'h4);
        expect_val("fetch_fc", S_FC, 32'h1);
        expect_val("fetch_mdr", S_MDR, 32'h8C22_0004);

        // Branch not taken, then taken.
        drive(0, 1, 0, 0, 2'b01, 32'h0, 32'h80, 32'h0);
        tick();
        idle();
        expect_val("br_nt_pc", S_PC, 32'h44);
        drive(0, 1, 1, 0, 2'b01, 32'h0, 32'h80, 32'h0);
        tick();
        idle();
        expect_val("br_t_pc", S_PC, 32'h80);

        // Set up a jump: PC to 0x1000_0004, then fetch the J instruction.
        drive(1, 0, 0, 0, 2'b00, 32'h1000_0004, 32'h0, 32'h0);
        tick();
        drive(1, 0, 0, 1, 2'b00, 32'h1000_0008, 32'h0, 32'h0800_0010);
        tick();
        idle();
        expect_val("jsetup_pc", S_PC, 32'h1000_0008);
        expect_val("jsetup_ir", S_IR, 32'h0800_0010);
        expect_val("jsetup_op", S_OP, 32'h2);
        expect_val("jsetup_fc", S_FC, 32'h2);
        drive(1, 0, 0, 0, 2'b10, 32'hDEAD_0000, 32'hBEEF_0000, 32'h0);
        tick();
        expect_val("jump_pc", S_PC, 32'h1000_0040);
        drive(1, 1, 1, 0, 2'b11, 32'hDEAD_0000, 32'hBEEF_0000, 32'h0);
        tick();
        idle();
        expect_val("hold_pc", S_PC, 32'h1000_0040);

        // Load path: address from alu_out, MDR captures, IR unchanged.
        i_or_d    = 1'b1;
        alu_out   = 32'h200;
        mem_rdata = 32'hCAFE_BABE;
        expect_val("load_addr", S_ADDR, 32'h200);
        tick();
        i_or_d    = 1'b0;
        mem_rdata = 32'h0;
        expect_val("load_mdr", S_MDR, 32'hCAFE_BABE);
        expect_val("load_ir", S_IR, 32'h0800_0010);
        expect_val("load_fc", S_FC, 32'h2);

        // Low-bit masking on both sequential and ALUOut sources.
        drive(1, 0, 0, 0, 2'b00, 32'h47, 32'h0, 32'h0);
        tick();
        expect_val("mask_res_pc", S_PC, 32'h44);
        drive(1, 0, 0, 0, 2'b01, 32'h0, 32'h203, 32'h0);
        tick();
        idle();
        expect_val("mask_out_pc", S_PC, 32'h200);

        // Counter wrap and negative immediate.
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count_q;
        drive(0, 0, 0, 1, 2'b11, 32'h0, 32'h0, 32'h1000_FFFC);
        tick();
        idle();
        mem_rdata = 32'h0;
        expect_val("wrap_fc", S_FC, 32'h0);
        expect_val("sext_ir", S_IR, 32'h1000_FFFC);
        expect_val("sext_imm", S_IMM, 32'hFFFF_FFFC);
        expect_val("sext_op", S_OP, 32'h4);
        expect_val("sext_pc", S_PC, 32'h200);

        // Asynchronous reset mid-run: visible before any clock edge.
        tick();
        rst_n = 1'b0;
        #1;
        expect_val("arst_pc", S_PC, 32'h40);
        expect_val("arst_ir", S_IR, 32'h0);
        expect_val("arst_mdr", S_MDR, 32'h0);
        expect_val("arst_fc", S_FC, 32'h0);
        expect_val("arst_imm", S_IMM, 32'h0);
        expect_val("arst_rs", S_RS, 32'h0);
        tick();
        rst_n = 1'b1;

        // Let the monitor drain, bounded.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
